// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Purpose:
//   Divider controller whose ratio can be changed at run time. It produces a
//   registered divided square wave (clk_out) and a one-cycle tick on every
//   rising edge of clk_out. Both run in the clk domain. Ratio and enable
//   commands come in over a valid/ready handshake. While the divider is
//   running, a command is only applied at a period boundary, so every output
//   period is complete and free of glitches.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   cfg_valid  in   command valid
//   cfg_ready  out  a command can be accepted this cycle (registered source)
//   cfg_en     in   1 = run with cfg_div, 0 = stop
//   cfg_div    in   half-period minus one (N); output period = 2*(N+1)
//   clk_out    out  divided square wave, registered
//   tick       out  one-cycle pulse with each 0->1 edge of clk_out
//   active     out  divider running
//   cur_div    out  N currently in use
//   pending    out  an accepted command is waiting for the period boundary
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             clk_out,
  output logic             tick,
  output logic             active,
  output logic [CNT_W-1:0] cur_div,
  output logic             pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             clk_out_q,  clk_out_d;
  logic             tick_q,     tick_d;
  logic             active_q,   active_d;
  logic [CNT_W-1:0] cur_div_q,  cur_div_d;
  logic             pending_q,  pending_d;
  logic             pend_en_q,  pend_en_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;

  logic accept;
  logic half_done;

  // cfg_ready depends only on a register. It has no path from cfg_valid.
  assign cfg_ready = ~pending_q;
  assign accept    = cfg_valid & cfg_ready;

  // The comparison is made before the increment, so with N = 2^CNT_W-1 the
  // counter never has to hold a value larger than N.
  assign half_done = (cnt_q == cur_div_q);

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves a signal unassigned. An unassigned signal would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    active_d   = active_q;
    cur_div_d  = cur_div_q;
    pending_d  = pending_q;
    pend_en_d  = pend_en_q;
    pend_div_d = pend_div_q;

    unique case (state_q)
      IDLE: begin
        clk_out_d = 1'b0;
        cnt_d     = '0;
        // In IDLE a command takes effect at once. A stop command is consumed
        // and changes nothing.
        if (accept && cfg_en) begin
          state_d   = HIGH;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
          active_d  = 1'b1;
          cur_div_d = cfg_div;
        end
      end

      HIGH: begin
        if (half_done) begin
          state_d   = LOW;
          clk_out_d = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      LOW: begin
        if (half_done) begin
          // Period boundary. Only a command that was already pending is
          // applied here. A command accepted in this same cycle is stored
          // below and waits for the next boundary.
          cnt_d = '0;
          if (pending_q && !pend_en_q) begin
            state_d   = IDLE;
            active_d  = 1'b0;
            pending_d = 1'b0;
          end else begin
            state_d   = HIGH;
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
            if (pending_q) begin
              cur_div_d = pend_div_q;
              pending_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        clk_out_d = 1'b0;
        active_d  = 1'b0;
        pending_d = 1'b0;
      end
    endcase

    // A command accepted while running is stored. accept requires
    // pending_q == 0, so this never conflicts with the clear above.
    if (accept && (state_q != IDLE)) begin
      pending_d  = 1'b1;
      pend_en_d  = cfg_en;
      pend_div_d = cfg_div;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // see the same pre-edge values, so the order of the statements does not
  // matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      active_q   <= 1'b0;
      cur_div_q  <= '0;
      pending_q  <= 1'b0;
      pend_en_q  <= 1'b0;
      pend_div_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      active_q   <= active_d;
      cur_div_q  <= cur_div_d;
      pending_q  <= pending_d;
      pend_en_q  <= pend_en_d;
      pend_div_q <= pend_div_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign active  = active_q;
  assign cur_div = cur_div_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Self-checking bench for clk_div_ctrl. The reference model tracks a single
// position inside the output period (0 .. 2*(N+1)-1), and every output is
// derived from that position. A compare process checks the DUT against the
// model on every falling edge. Directed scenarios pin the model with literal
// expectations, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_en;
  logic [CNT_W-1:0] cfg_div;
  logic             clk_out;
  logic             tick;
  logic             active;
  logic [CNT_W-1:0] cur_div;
  logic             pending;

  clk_div_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_en    (cfg_en),
    .cfg_div   (cfg_div),
    .clk_out   (clk_out),
    .tick      (tick),
    .active    (active),
    .cur_div   (cur_div),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a running flag, the position inside the period, the
  // ratio in use, and a one-entry command store.
  // ---------------------------------------------------------------------------
  bit m_run     = 1'b0;
  int m_pos     = 0;
  int m_div     = 0;
  bit m_pend    = 1'b0;
  bit m_pen_en  = 1'b0;
  int m_pen_div = 0;

  always @(posedge clk) begin
    bit acc;
    bit last;
    bit was_pend;
    if (rst) begin
      m_run = 0; m_pos = 0; m_div = 0; m_pend = 0; m_pen_en = 0; m_pen_div = 0;
    end else begin
      acc = cfg_valid && !m_pend;
      if (!m_run) begin
        if (acc && cfg_en) begin
          m_run = 1; m_pos = 0; m_div = int'(cfg_div);
        end
      end else begin
        last     = (m_pos == 2 * m_div + 1);
        was_pend = m_pend;
        if (last) begin
          m_pos = 0;
          if (was_pend) begin
            m_pend = 0;
            if (m_pen_en) m_div = m_pen_div;
            else          m_run = 0;
          end
        end else begin
          m_pos++;
        end
        if (acc) begin
          m_pend = 1; m_pen_en = cfg_en; m_pen_div = int'(cfg_div);
        end
      end
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("clk_out",   int'(clk_out),   int'(m_run && m_pos <= m_div));
      check("tick",      int'(tick),      int'(m_run && m_pos == 0));
      check("active",    int'(active),    int'(m_run));
      check("cur_div",   int'(cur_div),   m_div);
      check("pending",   int'(pending),   int'(m_pend));
      check("cfg_ready", int'(cfg_ready), int'(!m_pend));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Every helper is entered and left at a falling edge.
  // ---------------------------------------------------------------------------
  // Present a command and hold it until it is accepted. On return the caller
  // is in the first cycle after acceptance.
  task automatic send(input bit en, input int div);
    int budget = 0;
    cfg_valid = 1'b1;
    cfg_en    = en;
    cfg_div   = div[CNT_W-1:0];
    while (!cfg_ready && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("send_ready", int'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Record clk_out and tick for n consecutive cycles. Bit i is cycle i.
  task automatic grab(input int n, output logic [15:0] c, output logic [15:0] t);
    c = '0;
    t = '0;
    for (int i = 0; i < n; i++) begin
      c[i] = clk_out;
      t[i] = tick;
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [15:0] cv, tv;
  int hi_a, hi_b, ticks;

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_en    = 1'b0;
    cfg_div   = '0;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Reset held for two cycles while running with N=3.
    send(1'b1, 3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_clk_out", int'(clk_out),   0);
    check("rst_tick",    int'(tick),      0);
    check("rst_active",  int'(active),    0);
    check("rst_pending", int'(pending),   0);
    check("rst_cur_div", int'(cur_div),   0);
    check("rst_ready",   int'(cfg_ready), 1);

    // N=0 from IDLE: toggles every cycle, tick every two cycles.
    send(1'b1, 0);
    check("n0_active", int'(active), 1);
    grab(6, cv, tv);
    check("n0_clk_pattern",  int'(cv), 'h15);
    check("n0_tick_pattern", int'(tv), 'h15);

    // N=2: 3 cycles high, 3 cycles low.
    pulse_reset();
    send(1'b1, 2);
    check("n2_cur_div", int'(cur_div), 2);
    grab(12, cv, tv);
    check("n2_clk_pattern",  int'(cv), 'h1C7);
    check("n2_tick_pattern", int'(tv), 'h041);

    // Ratio change accepted in the second HIGH cycle of a period.
    @(negedge clk);
    cfg_valid = 1'b1; cfg_en = 1'b1; cfg_div = 8'd0;
    @(negedge clk);
    check("chg_pending", int'(pending),   1);
    check("chg_ready",   int'(cfg_ready), 0);
    check("chg_clk",     int'(clk_out),   1);
    cfg_div = 8'd5;  // a second command held while the first is pending
    grab(4, cv, tv);
    check("chg_old_period_clk",  int'(cv[3:0]), 'h1);
    check("chg_old_period_tick", int'(tv[3:0]), 'h0);
    check("chg_apply_tick",    int'(tick),      1);
    check("chg_apply_cur_div", int'(cur_div),   0);
    check("chg_apply_pending", int'(pending),   0);
    check("chg_apply_ready",   int'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    check("chg2_pending", int'(pending), 1);
    check("chg2_clk",     int'(clk_out), 0);
    @(negedge clk);
    check("chg2_cur_div", int'(cur_div), 5);
    check("chg2_tick",    int'(tick),    1);

    // Stop command accepted exactly on the boundary cycle with N=1.
    pulse_reset();
    send(1'b1, 1);
    repeat (3) @(negedge clk);
    cfg_valid = 1'b1; cfg_en = 1'b0; cfg_div = 8'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("stop_pending", int'(pending), 1);
    check("stop_tick",    int'(tick),    1);
    grab(4, cv, tv);
    check("stop_last_clk",  int'(cv[3:0]), 'h3);
    check("stop_last_tick", int'(tv[3:0]), 'h1);
    check("stop_active",  int'(active),    0);
    check("stop_clk",     int'(clk_out),   0);
    check("stop_pend",    int'(pending),   0);
    check("stop_ready",   int'(cfg_ready), 1);
    grab(10, cv, tv);
    check("stop_no_tick", int'(tv[9:0]), 0);

    // Maximum ratio N=255: 256 cycles high, 256 cycles low.
    pulse_reset();
    send(1'b1, 255);
    hi_a = 0; hi_b = 0; ticks = 0;
    for (int i = 0; i < 512; i++) begin
      if (i < 256) hi_a += int'(clk_out);
      else         hi_b += int'(clk_out);
      ticks += int'(tick);
      @(negedge clk);
    end
    check("max_high_cycles", hi_a,  256);
    check("max_low_highs",   hi_b,  0);
    check("max_ticks",       ticks, 1);
    check("max_next_tick",   int'(tick), 1);

    // Randomized commands with occasional resets.
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 249) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_en    = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 19) == 0) cfg_div = CNT_W'($urandom_range(0, 255));
      else                            cfg_div = CNT_W'($urandom_range(0, 5));
      @(negedge clk);
    end
    rst       = 1'b0;
    cfg_valid = 1'b0;
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
